// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port A arbiter: FSM encoding and
// default geometry / retry limit.
package regfile_arb_pkg;

  localparam int DW_DEF        = 16;
  localparam int AW_DEF        = 4;
  localparam int MAX_RETRY_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RETRY = 3'd2,
    GRANT = 3'd3,
    DONE  = 3'd4
  } arb_state_e;

  // Counter must be able to hold MAX_RETRY itself.
  function automatic int retry_cnt_width(input int max_retry);
    return (max_retry < 2) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Port A sharing bundle: pipeline requests, register-file port A and the debug
// read handshake. slave = arbiter side, master = pipeline/debug/register-file side.
interface regfile_port_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          advance;
  logic          wb_we;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wd;
  logic [AW-1:0] id_ra;
  logic [DW-1:0] rf_rd1;
  logic [AW-1:0] rf_rwa1;
  logic          rf_we;
  logic          dbg_req;
  logic [AW-1:0] dbg_ra;
  logic          dbg_grant;
  logic [DW-1:0] dbg_rd;
  logic          dbg_err;

  modport slave (
    input  advance, wb_we, wb_wa, wb_wd, id_ra, rf_rd1, dbg_req, dbg_ra,
    output rf_rwa1, rf_we, dbg_grant, dbg_rd, dbg_err
  );

  modport master (
    output advance, wb_we, wb_wa, wb_wd, id_ra, rf_rd1, dbg_req, dbg_ra,
    input  rf_rwa1, rf_we, dbg_grant, dbg_rd, dbg_err
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares register-file port A between the pipeline (always wins on advance) and
// debug reads slotted into idle cycles. Optional macro ARB_WB_FWD_EN forwards WB data.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_port_arbiter_if.slave bus
);

  localparam int CW = retry_cnt_width(MAX_RETRY);

  arb_state_e    state_reg, state_next;
  logic [AW-1:0] ra_reg, ra_next;
  logic [DW-1:0] rd_reg, rd_next;
  logic          err_reg, err_next;
  logic [CW-1:0] retry_reg, retry_next;
  logic [CW-1:0] retry_inc;
  logic          fwd_hit;
  logic [AW-1:0] rwa_mux;

  assign retry_inc = retry_reg + 1'b1;

`ifdef ARB_WB_FWD_EN
  // A WB write to the address being read supplies the post-write value directly.
  assign fwd_hit = bus.advance & bus.wb_we & (bus.wb_wa == ra_reg);
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ra_reg    <= '0;
      rd_reg    <= '0;
      err_reg   <= 1'b0;
      retry_reg <= '0;
    end else begin
      state_reg <= state_next;
      ra_reg    <= ra_next;
      rd_reg    <= rd_next;
      err_reg   <= err_next;
      retry_reg <= retry_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ra_next    = ra_reg;
    rd_next    = rd_reg;
    err_next   = err_reg;
    retry_next = retry_reg;
    case (state_reg)
      IDLE: begin
        if (bus.dbg_req && !bus.advance) begin
          ra_next    = bus.dbg_ra;
          state_next = SETUP;
        end
      end
      SETUP, RETRY: begin
        if (!bus.dbg_req) begin
          state_next = IDLE;
          retry_next = '0;
          err_next   = 1'b0;
        end else if (fwd_hit) begin
          rd_next    = bus.wb_wd;
          err_next   = 1'b0;
          state_next = GRANT;
        end else if (state_reg == RETRY) begin
          if (!bus.advance) begin
            state_next = SETUP;
          end
        end else if (bus.advance) begin
          // Pipeline stole the port during our setup cycle.
          retry_next = retry_inc;
          if (retry_inc == CW'(MAX_RETRY)) begin
            rd_next    = '0;
            err_next   = 1'b1;
            state_next = GRANT;
          end else begin
            state_next = RETRY;
          end
        end else begin
          rd_next    = bus.rf_rd1;
          err_next   = 1'b0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!bus.dbg_req) begin
          state_next = DONE;
        end
      end
      DONE: begin
        retry_next = '0;
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rwa_mux = bus.id_ra;
    if (bus.advance && bus.wb_we) begin
      rwa_mux = bus.wb_wa;
    end else if (bus.advance) begin
      rwa_mux = bus.id_ra;
    end else if (state_reg == SETUP) begin
      rwa_mux = ra_reg;
    end
  end

  assign bus.rf_rwa1   = rwa_mux;
  assign bus.rf_we     = bus.wb_we & bus.advance;
  assign bus.dbg_grant = (state_reg == GRANT);
  assign bus.dbg_rd    = rd_reg;
  assign bus.dbg_err   = err_reg;

  a_we_only_on_advance: assert property (@(posedge clk) disable iff (!rst)
    bus.rf_we |-> bus.advance);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Randomized scoreboard bench for regfile_port_arbiter with a transaction-level
// reference model of the debug read protocol and a behavioural register file.
module tb_regfile_port_arbiter;
  import regfile_arb_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int MAXR = MAX_RETRY_DEF;
  localparam int PL   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_port_arbiter_if #(.DW(DW), .AW(AW)) ifc ();

  regfile_port_arbiter #(.DW(DW), .AW(AW), .MAX_RETRY(MAXR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] regs [16];
  always @(posedge clk) if (ifc.rf_we) regs[ifc.rf_rwa1] <= ifc.wb_wd;
  assign ifc.rf_rd1 = regs[ifc.rf_rwa1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    bit            err;
    int            gcyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] last_rd;
  logic          last_err;

  bit            p_adv [PL];
  bit            p_we  [PL];
  logic [AW-1:0] p_wa  [PL];
  logic [AW-1:0] p_id  [PL];
  logic [DW-1:0] p_wd  [PL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pipeline-side rules, every cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rf_we_rule", 32'(ifc.rf_we), 32'(ifc.advance & ifc.wb_we));
      if (ifc.advance)
        chk("rwa1_on_advance", 32'(ifc.rf_rwa1), 32'(ifc.wb_we ? ifc.wb_wa : ifc.id_ra));
    end
  end

  // Scoreboard monitor: pops one expectation per grant.
  bit   grant_prev = 1'b0;
  bit   have_cur   = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst) begin
      grant_prev = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (ifc.dbg_grant && !grant_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(ifc.dbg_grant), 32'd0);
          have_cur = 1'b0;
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          chk("grant_cycle", 32'(cyc), 32'(cur.gcyc));
        end
      end
      if (ifc.dbg_grant && have_cur) begin
        chk("grant_rd", 32'(ifc.dbg_rd), 32'(cur.data));
        chk("grant_err", 32'(ifc.dbg_err), 32'(cur.err));
      end
      grant_prev = ifc.dbg_grant;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_plan(input int k);
    ifc.advance = p_adv[k];
    ifc.wb_we   = p_we[k];
    ifc.wb_wa   = p_wa[k];
    ifc.wb_wd   = p_wd[k];
    ifc.id_ra   = p_id[k];
  endtask

  task automatic rand_pipe();
    ifc.advance = 1'($urandom);
    ifc.wb_we   = 1'($urandom);
    ifc.wb_wa   = 4'($urandom);
    ifc.wb_wd   = 16'($urandom);
    ifc.id_ra   = 4'($urandom);
  endtask

  // mode 0 random, 1 idle pipe, 2 single steal of first setup, 3 steal every setup,
  // 4 WB write of 16'h1234 to the read address on the stealing advance.
  task automatic gen_plan(input int mode, input logic [AW-1:0] ra);
    int pct;
    pct = int'($urandom_range(70, 20));
    for (int k = 0; k < PL; k++) begin
      p_id[k] = 4'($urandom);
      p_wd[k] = 16'($urandom);
      p_wa[k] = ($urandom_range(3) == 0) ? ra : 4'($urandom);
      case (mode)
        0: begin
          p_adv[k] = (k < 48) && ($urandom_range(99) < 32'(pct));
          p_we[k]  = 1'($urandom);
        end
        2: begin p_adv[k] = (k == 1); p_we[k] = 1'b0; end
        3: begin p_adv[k] = (k % 2 == 1); p_we[k] = 1'b0; end
        4: begin
          p_adv[k] = (k == 1);
          p_we[k]  = (k == 1);
          if (k == 1) begin p_wa[k] = ra; p_wd[k] = 16'h1234; end
        end
        default: begin p_adv[k] = 1'b0; p_we[k] = 1'b0; end
      endcase
    end
  endtask

  // Reference model: a read needs a free port cycle to latch, then one more to read;
  // a steal during the read attempt costs one retry, MAXR of them end in an error.
  task automatic predict(input logic [AW-1:0] ra, output int kl, output int kg,
                         output logic [DW-1:0] d, output bit e);
    logic [DW-1:0] sh [16];
    int aborts;
    bit waiting;
    bit fwd;
    sh = regs;
    aborts = 0; waiting = 1'b1; kl = -1; kg = -1; d = '0; e = 1'b0;
    for (int k = 0; k < PL && kg < 0; k++) begin
      fwd = 1'b0;
`ifdef ARB_WB_FWD_EN
      fwd = (!waiting || aborts > 0) && p_adv[k] && p_we[k] && (p_wa[k] == ra);
`endif
      if (fwd) begin
        d = p_wd[k]; e = 1'b0; kg = k;
      end else if (waiting) begin
        if (!p_adv[k]) begin
          waiting = 1'b0;
          if (kl < 0) kl = k;
        end
      end else if (p_adv[k]) begin
        aborts++;
        if (aborts == MAXR) begin d = '0; e = 1'b1; kg = k; end
        else waiting = 1'b1;
      end else begin
        d = sh[ra]; e = 1'b0; kg = k;
      end
      if (p_adv[k] && p_we[k]) sh[p_wa[k]] = p_wd[k];
    end
  endtask

  // action 0 complete normally, 1 cancel in setup, 2 reset while granted
  task automatic run_txn(input int mode, input logic [AW-1:0] ra, input int action);
    int kl, kg, s, kend;
    logic [DW-1:0] d;
    bit e;
    exp_t x;
    next_cycle();
    gen_plan(mode, ra);
    predict(ra, kl, kg, d, e);
    s = cyc;
    if (action != 1) begin
      x.data = d; x.err = e; x.gcyc = s + kg + 1;
      exp_q.push_back(x);
    end
    kend = (action == 1) ? kl : kg;
    for (int k = 0; k <= kend; k++) begin
      if (k > 0) next_cycle();
      drive_plan(k);
      ifc.dbg_req = 1'b1;
      ifc.dbg_ra  = (k <= kl) ? ra : 4'($urandom);
    end
    if (action == 1) begin
      next_cycle();
      ifc.dbg_req = 1'b0;
      rand_pipe();
      for (int i = 0; i < 3; i++) begin
        next_cycle();
        rand_pipe();
        chk("cancel_no_grant", 32'(ifc.dbg_grant), 32'd0);
      end
    end else begin
      next_cycle();
      rand_pipe();
      chk("grant_high", 32'(ifc.dbg_grant), 32'd1);
      if (action == 2) begin
        #5 rst = 1'b0;
        #1;
        chk("rst_grant", 32'(ifc.dbg_grant), 32'd0);
        chk("rst_rd", 32'(ifc.dbg_rd), 32'd0);
        chk("rst_err", 32'(ifc.dbg_err), 32'd0);
        ifc.dbg_req = 1'b0;
        ifc.advance = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
      end else begin
        repeat ($urandom_range(2)) begin
          next_cycle();
          rand_pipe();
        end
        next_cycle();
        ifc.dbg_req = 1'b0;
        rand_pipe();
        chk("rd_held", 32'(ifc.dbg_rd), 32'(d));
        last_rd  = ifc.dbg_rd;
        last_err = ifc.dbg_err;
        next_cycle();
        rand_pipe();
        chk("grant_drop", 32'(ifc.dbg_grant), 32'd0);
      end
    end
  endtask

  initial begin
    ifc.advance = 1'b0; ifc.wb_we = 1'b0; ifc.wb_wa = '0; ifc.wb_wd = '0;
    ifc.id_ra = '0; ifc.dbg_req = 1'b0; ifc.dbg_ra = '0;
    for (int i = 0; i < 16; i++) regs[i] <= 16'($urandom);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", 32'(ifc.dbg_grant), 32'd0);
    chk("reset_rd", 32'(ifc.dbg_rd), 32'd0);
    chk("reset_err", 32'(ifc.dbg_err), 32'd0);
    chk("reset_rf_we", 32'(ifc.rf_we), 32'd0);
    regs[5] <= 16'hBEEF;
    rst = 1'b1;

    run_txn(1, 4'd5, 0);
    chk("idle_read_beef", 32'(last_rd), 32'hBEEF);
    chk("idle_read_err", 32'(last_err), 32'd0);

    run_txn(2, 4'($urandom), 0);

    run_txn(3, 4'($urandom), 0);
    chk("max_retry_err", 32'(last_err), 32'd1);
    chk("max_retry_rd", 32'(last_rd), 32'd0);

    run_txn(4, 4'd3, 0);
    chk("wb_collision_rd", 32'(last_rd), 32'h1234);

    run_txn(1, 4'($urandom), 2);
    run_txn(1, 4'($urandom), 0);
    run_txn(0, 4'($urandom), 1);

    for (int t = 0; t < 40; t++)
      run_txn(0, 4'($urandom), ($urandom_range(5) == 0) ? 1 : 0);

    ifc.advance = 1'b0;
    ifc.wb_we   = 1'b0;
    repeat (3) next_cycle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
